// File: rtl/timer_apb_regif.sv
// APB register interface for an 8-bit timer: TDR/TCR/TSR/TCNT
// decode, wait-state transfer FSM and sticky event flags.
module timer_apb_regif #(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic [7:0] cnt,
  input  logic       ovf_pls,
  input  logic       udf_pls,
  output logic [7:0] tdr,
  output logic       load,
  output logic       dw,
  output logic       en,
  output logic [1:0] clk_sel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [7:0] TCR_MASK = 8'hB3;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tdr;
  logic [7:0] r_tcr;
  logic [1:0] r_tsr;

  logic       w_ack;
  logic       w_err;
  logic       w_wr;
  logic [1:0] w_clr;
  logic [7:0] w_rdata;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (psel && !penable) w_next = S_SETUP;
      S_SETUP: if (penable) w_next = WAIT_EN ? S_WAIT : S_ACK;
      S_WAIT:  w_next = S_ACK;
      S_ACK:   w_next = (psel && !penable) ? S_SETUP : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (!psel) w_next = S_IDLE;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign w_ack = (r_state == S_ACK);
  assign w_err = (paddr > 8'h03);
  assign w_wr  = w_ack && pwrite && !w_err;

  // write-0-to-clear: a 0 in the written bit clears that flag
  assign w_clr = (w_wr && paddr == 8'h02) ? ~pwdata[1:0] : 2'b00;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_tdr <= 8'h00;
      r_tcr <= 8'h00;
      r_tsr <= 2'b00;
    end else begin
      if (w_wr && paddr == 8'h00) r_tdr <= pwdata;
      if (w_wr && paddr == 8'h01) r_tcr <= pwdata & TCR_MASK;
      // events win over a clearing write in the same cycle
      r_tsr <= {udf_pls, ovf_pls} | (r_tsr & ~w_clr);
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    unique case (paddr)
      8'h00:   w_rdata = r_tdr;
      8'h01:   w_rdata = r_tcr;
      8'h02:   w_rdata = {6'b0, r_tsr};
      8'h03:   w_rdata = cnt;
      default: w_rdata = 8'h00;
    endcase
  end

  assign prdata  = (w_ack && !pwrite) ? w_rdata : 8'h00;
  assign pready  = w_ack;
  assign pslverr = w_ack && w_err;

  assign tdr     = r_tdr;
  assign load    = r_tcr[7];
  assign dw      = r_tcr[5];
  assign en      = r_tcr[4];
  assign clk_sel = r_tcr[1:0];

endmodule

// File: tb/tb_timer_apb_regif.sv
// Scoreboard bench for timer_apb_regif: stimulus queues expected
// APB responses, a monitor pops them on every pready.
module tb_timer_apb_regif;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic [7:0] cnt;
  logic       ovf_pls, udf_pls;
  logic [7:0] tdr;
  logic       load, dw, en;
  logic [1:0] clk_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    bit         chk_rd;
  } exp_t;

  exp_t q[$];
  exp_t me;

  timer_apb_regif #(.WAIT_EN(1'b1)) dut (
    .pclk(pclk), .preset(preset),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .cnt(cnt), .ovf_pls(ovf_pls), .udf_pls(udf_pls),
    .tdr(tdr), .load(load), .dw(dw), .en(en), .clk_sel(clk_sel)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge pclk) begin
    if (pready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready addr=%h", paddr);
      end else begin
        me = q.pop_front();
        checks++;
        if (pslverr !== me.err) begin
          errors++;
          $display("FAIL pslverr addr=%h got %b exp %b",
                   paddr, pslverr, me.err);
        end
        if (me.chk_rd) begin
          checks++;
          if (prdata !== me.rd) begin
            errors++;
            $display("FAIL prdata addr=%h got %h exp %h",
                     paddr, prdata, me.rd);
          end
        end
      end
    end else begin
      checks++;
      if (prdata !== 8'h00 || pslverr !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs got prdata=%h pslverr=%b exp 00/0",
                 prdata, pslverr);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic xfer(input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] er,
                      input bit ee, input bit pls);
    exp_t e;
    int   n;
    e.rd = er;
    e.err = ee;
    e.chk_rd = !wr;
    q.push_back(e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (pready !== 1'b1 && n < 8) begin
      @(posedge pclk); #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL latency addr=%h got %0d exp 2", a, n);
    end
    if (pls) udf_pls = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    udf_pls = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d,
                    input bit ee);
    xfer(1'b1, a, d, 8'h00, ee, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] er,
                    input bit ee);
    xfer(1'b0, a, 8'h00, er, ee, 1'b0);
  endtask

  task automatic pulse(input bit o, input bit u);
    @(posedge pclk); #1;
    ovf_pls = o; udf_pls = u;
    @(posedge pclk); #1;
    ovf_pls = 1'b0; udf_pls = 1'b0;
  endtask

  initial begin
    preset = 1'b1;
    psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; cnt = 0;
    ovf_pls = 0; udf_pls = 0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_tdr", tdr, 8'h00);
    chk("rst_ctl", {3'b0, load, dw, en, clk_sel}, 8'h00);
    chk("rst_pready", {7'b0, pready}, 8'h00);
    preset = 1'b0;

    rd(8'h00, 8'h00, 1'b0);
    rd(8'h01, 8'h00, 1'b0);
    rd(8'h02, 8'h00, 1'b0);

    wr(8'h00, 8'hFF, 1'b0);
    chk("tdr_after_wr", tdr, 8'hFF);
    wr(8'h01, 8'h80, 1'b0);
    chk("load_after_wr", {7'b0, load}, 8'h01);
    rd(8'h01, 8'h80, 1'b0);
    rd(8'h00, 8'hFF, 1'b0);

    wr(8'h01, 8'hFF, 1'b0);
    rd(8'h01, 8'hB3, 1'b0);
    chk("ctl_ff", {3'b0, load, dw, en, clk_sel}, 8'h1F);

    pulse(1'b0, 1'b1);
    rd(8'h02, 8'h02, 1'b0);
    wr(8'h02, 8'h00, 1'b0);
    rd(8'h02, 8'h00, 1'b0);

    pulse(1'b1, 1'b1);
    rd(8'h02, 8'h03, 1'b0);
    wr(8'h02, 8'h01, 1'b0);
    rd(8'h02, 8'h01, 1'b0);
    xfer(1'b1, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1);
    rd(8'h02, 8'h02, 1'b0);

    rd(8'h10, 8'h00, 1'b1);
    wr(8'h10, 8'hAA, 1'b1);
    rd(8'h00, 8'hFF, 1'b0);
    rd(8'h01, 8'hB3, 1'b0);
    rd(8'h02, 8'h02, 1'b0);
    cnt = 8'h5A;
    rd(8'h03, 8'h5A, 1'b0);
    wr(8'h03, 8'h00, 1'b0);
    rd(8'h00, 8'hFF, 1'b0);
    rd(8'h03, 8'h5A, 1'b0);

    wr(8'h01, 8'h00, 1'b0);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h30;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    #1;
    chk("abort_rst_pready", {7'b0, pready}, 8'h00);
    chk("abort_rst_tdr", tdr, 8'h00);
    #1;
    preset = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("abort_no_pready", {7'b0, pready}, 8'h00);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("abort_en", {6'b0, dw, en}, 8'h00);
    rd(8'h01, 8'h00, 1'b0);
    wr(8'h01, 8'h30, 1'b0);
    chk("after_abort_ctl", {3'b0, load, dw, en, clk_sel}, 8'h0C);
    rd(8'h01, 8'h30, 1'b0);

    repeat (3) @(posedge pclk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got %0d exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_apb_regif.md
TIMER_APB_REGIF -- requirements
Module: timer_apb_regif

Interface
REQ-001 SHALL have ports: pclk  in  1  APB/system clock, all state on its rising edge.
REQ-002 SHALL have ports: preset  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: psel  in  1, penable  in  1, pwrite  in  1, paddr  in  8, pwdata  in  8  APB request signals.
REQ-004 SHALL have ports: prdata  out  8, pready  out  1, pslverr  out  1  APB response signals.
REQ-005 SHALL have ports: cnt  in  8  live counter value from the timer counter stage.
REQ-006 SHALL have ports: ovf_pls  in  1 and udf_pls  in  1  single-cycle overflow/underflow events from the counter.
REQ-007 SHALL have ports: tdr  out  8, load  out  1, dw  out  1, en  out  1, clk_sel  out  2  counter controls, each driven directly from register bits.
REQ-008 SHALL have parameter WAIT_EN, default 1, meaning: insert exactly one wait state on every access.
REQ-009 SHALL decode these addresses: TDR=0x00 (RW), TCR=0x01 (RW), TSR=0x02 (RW, write-0-to-clear), TCNT=0x03 (RO).

Function
REQ-010 SHALL implement a transfer FSM with states IDLE, SETUP, WAIT, ACK.
- IDLE->SETUP on psel=1 and penable=0.
- SETUP->WAIT on penable=1 when WAIT_EN=1, else SETUP->ACK.
- WAIT->ACK unconditionally.
- ACK->SETUP if psel=1 and penable=0, else ACK->IDLE.
- psel=0 in any state -> IDLE.
REQ-011 SHALL assert pready only in ACK, for exactly one cycle per transfer.
REQ-012 SHALL commit a write on the ACK cycle only: one register update per transfer.
REQ-013 SHALL drive prdata with the read value in ACK and with 0x00 in all other states.
REQ-014 SHALL map TCR bits as: bit7 load, bit5 dw, bit4 en, bits1:0 clk_sel; bits 6 and 3:2 SHALL ignore writes and read 0.
REQ-015 SHALL map TSR bits as: bit0 ovf, bit1 udf; bits 7:2 SHALL read 0.
REQ-016 SHALL set TSR.ovf/udf on the cycle after ovf_pls/udf_pls, and the flag SHALL stay set until cleared.
REQ-017 SHALL clear a TSR flag when a write carries 0 in that bit position; writing 1 SHALL leave the flag unchanged.
REQ-018 SHALL give set priority over clear: an event pulse in the same cycle as a clearing write leaves the flag at 1.
REQ-019 SHALL return cnt as sampled in the ACK cycle on a TCNT read; a write to TCNT SHALL change nothing and SHALL not raise an error.
REQ-020 SHALL, for paddr>0x03, assert pslverr together with pready, return prdata=0x00, and change no register.
REQ-021 SHALL keep pslverr=0 in every state other than ACK.
REQ-022 SHALL present TCR.load as the level on the load output; the bit stays 1 until software writes it to 0.
REQ-023 SHALL make a new TDR or TCR value visible on its outputs in the cycle after ACK.

Reset
REQ-024 SHALL, while preset=1, hold: FSM=IDLE, TDR=0x00, TCR=0x00, TSR=0x00, prdata=0x00, pready=0, pslverr=0, and all counter controls at 0.
REQ-025 SHALL, if preset is asserted mid-transfer, abort the transfer with no register update; after release the FSM SHALL wait for a fresh SETUP.

Verification
REQ-026 SHALL pass: write TDR=0xFF, then TCR=0x80 -> tdr=0xFF, load=1 one cycle after each ACK; read TCR -> 0x80.
REQ-027 SHALL pass: write TCR=0xFF -> read TCR=0xB3; dw=1, en=1, clk_sel=3, load=1.
REQ-028 SHALL pass: pulse udf_pls -> read TSR=0x02; write TSR=0x00 -> read TSR=0x00.
REQ-029 SHALL pass: ovf_pls and udf_pls both set, then write TSR=0x01 -> TSR=0x01; pulse udf_pls in the ACK cycle of a TSR=0x00 write -> TSR=0x02.
REQ-030 SHALL pass: read paddr=0x10 -> pslverr=1, prdata=0x00; a write to 0x10 leaves all registers unchanged; drive cnt=0x5A and read TCNT -> 0x5A.
REQ-031 SHALL pass: assert preset during the WAIT state of a TCR=0x30 write -> TCR stays 0x00; the next access completes normally with pready two cycles after SETUP.
